// File: rtl/ula_seq_pkg.sv
// Shared definitions for the ULA sequencer: FSM state type, instruction field
// positions and the constant the SrcB MUX selects when alu_src is high.
package ula_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } seq_state_t;

  localparam int OP_HI     = 15;
  localparam int OP_LO     = 13;
  localparam int WA_HI     = 12;
  localparam int WA_LO     = 10;
  localparam int RA1_HI    = 9;
  localparam int RA1_LO    = 7;
  localparam int RA2_HI    = 6;
  localparam int RA2_LO    = 4;
  localparam int CONST_BIT = 3;

  // Value the datapath MUX feeds to SrcB when alu_src=1; the MUX itself holds it.
  localparam logic [7:0] SEQ_CONST = 8'h07;

  // Register 0 is hard-wired read-only in the RegisterFile.
  function automatic logic is_writable(input logic [2:0] addr);
    return addr != 3'd0;
  endfunction

endpackage

// File: rtl/ula_seq_perf.sv
// Optional performance counters for the ULA sequencer (built only when
// ULA_SEQ_PERF_EN is defined): completed instructions and zero results.
module ula_seq_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_pulse,
  input  logic        z_flag,
  output logic [15:0] instr_count,
  output logic [7:0]  zero_count
);

  // instr_count wraps naturally; zero_count sticks at its maximum.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_count <= 16'd0;
      zero_count  <= 8'd0;
    end else if (wb_pulse) begin
      instr_count <= instr_count + 16'd1;
      if (z_flag && (zero_count != 8'hFF)) begin
        zero_count <= zero_count + 8'd1;
      end
    end
  end

endmodule

// File: rtl/ula_sequencer.sv
// Multi-cycle control unit driving RegisterFile/MUX/ULA through DECODE, EXEC, WB.
// Optional ULA_SEQ_PERF_EN adds instr_count/zero_count outputs.
module ula_sequencer
  import ula_seq_pkg::*;
#(
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               z_in,
  output logic [2:0]         ula_control,
  output logic [2:0]         ra1,
  output logic [2:0]         ra2,
  output logic [2:0]         wa3,
  output logic               alu_src,
  output logic               we3,
  output logic               z_flag,
  output logic               done,
  output logic               busy
`ifdef ULA_SEQ_PERF_EN
  ,
  output logic [15:0]        instr_count,
  output logic [7:0]         zero_count
`endif
);

  seq_state_t state, state_next;
  logic [INSTR_W-1:3] ir;
  logic accept;
  logic unused_reserved;

  assign unused_reserved = ^instr[2:0];
  assign accept = instr_valid && instr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ir only loads at the handshake, so the decoded outputs below hold their
  // last values through IDLE instead of dropping to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir     <= '0;
      z_flag <= 1'b0;
    end else begin
      if (accept) begin
        ir <= instr[INSTR_W-1:3];
      end
      if (state == S_EXEC) begin
        z_flag <= z_in;
      end
    end
  end

  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    we3         = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (instr_valid) begin
          state_next = S_DECODE;
        end
      end
      S_DECODE: state_next = S_EXEC;
      S_EXEC:   state_next = S_WB;
      S_WB: begin
        done       = 1'b1;
        // A reset landing on the WB edge must not commit the write.
        we3        = is_writable(ir[WA_HI:WA_LO]) && !rst;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign ula_control = ir[OP_HI:OP_LO];
  assign wa3         = ir[WA_HI:WA_LO];
  assign ra1         = ir[RA1_HI:RA1_LO];
  assign ra2         = ir[RA2_HI:RA2_LO];
  assign alu_src     = ir[CONST_BIT];

`ifdef ULA_SEQ_PERF_EN
  ula_seq_perf u_perf (
    .clk         (clk),
    .rst         (rst),
    .wb_pulse    (done),
    .z_flag      (z_flag),
    .instr_count (instr_count),
    .zero_count  (zero_count)
  );
`endif

endmodule

// File: tb/tb_ula_sequencer.sv
// Self-checking bench for ula_sequencer: transaction-level model plus datapath
// model, checked every cycle, with directed literal expectations.
module tb_ula_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        z_in;
  logic [2:0]  ula_control, ra1, ra2, wa3;
  logic        alu_src, we3, z_flag, done, busy;
`ifdef ULA_SEQ_PERF_EN
  logic [15:0] instr_count;
  logic [7:0]  zero_count;
`endif

  always #5 clk = ~clk;

  ula_sequencer #(.INSTR_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .z_in        (z_in),
    .ula_control (ula_control),
    .ra1         (ra1),
    .ra2         (ra2),
    .wa3         (wa3),
    .alu_src     (alu_src),
    .we3         (we3),
    .z_flag      (z_flag),
    .done        (done),
    .busy        (busy)
`ifdef ULA_SEQ_PERF_EN
    ,
    .instr_count (instr_count),
    .zero_count  (zero_count)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  // Transaction model: cycles elapsed since the accepted instruction (0 = idle).
  int          phase = 0;
  logic [2:0]  m_op = 3'd0, m_wa = 3'd0, m_ra1 = 3'd0, m_ra2 = 3'd0;
  logic        m_const = 1'b0, m_z = 1'b0;
  logic [15:0] m_count = 16'd0;
  logic [7:0]  m_zc = 8'd0;
  logic [7:0]  rf [8];
  int          we3_pulses = 0;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] aluModel(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  // Datapath model driven by the sequencer's outputs, then the transaction model.
  always @(posedge clk) begin
    if (we3) begin
      rf[wa3] = aluModel(ula_control, rf[ra1], alu_src ? 8'h07 : rf[ra2]);
      we3_pulses++;
    end
    if (rst) begin
      phase = 0; m_op = 0; m_wa = 0; m_ra1 = 0; m_ra2 = 0; m_const = 0;
      m_z = 0; m_count = 0; m_zc = 0;
    end else begin
      case (phase)
        0: if (instr_valid) begin
          m_op = instr[15:13]; m_wa = instr[12:10]; m_ra1 = instr[9:7];
          m_ra2 = instr[6:4]; m_const = instr[3]; phase = 1;
        end
        1: phase = 2;
        2: begin m_z = z_in; phase = 3; end
        default: begin
          phase = 0;
          m_count = m_count + 16'd1;
          if (m_z && m_zc != 8'hFF) m_zc = m_zc + 8'd1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("instr_ready", instr_ready, phase == 0);
      checkOutput("busy", busy, phase != 0);
      checkOutput("done", done, phase == 3);
      checkOutput("we3", we3, (phase == 3) && (m_wa != 3'd0) && !rst);
      checkOutput("ula_control", ula_control, m_op);
      checkOutput("ra1", ra1, m_ra1);
      checkOutput("ra2", ra2, m_ra2);
      checkOutput("wa3", wa3, m_wa);
      checkOutput("alu_src", alu_src, m_const);
      checkOutput("z_flag", z_flag, m_z);
`ifdef ULA_SEQ_PERF_EN
      checkOutput("instr_count", instr_count, m_count);
      checkOutput("zero_count", zero_count, m_zc);
`endif
    end
  end

  // One instruction with z_in driven during EXEC; returns at the WB negedge.
  task automatic applyStimulus(input logic [15:0] w, input logic zexec);
    @(posedge clk); #1; instr = w; instr_valid = 1'b1;
    @(posedge clk); #1; instr_valid = 1'b0; instr = ~w;
    @(posedge clk); #1; z_in = zexec;
    @(posedge clk); #1; z_in = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int p;
    int n;
    int accepts[$];
    for (int i = 0; i < 8; i++) rf[i] = 8'(i * 16);
    rst = 1'b1; instr = 16'd0; instr_valid = 1'b0; z_in = 1'b0;
    repeat (2) @(posedge clk);
    #1; check_en = 1'b1;
    @(posedge clk); #1; rst = 1'b0;

    repeat (10) begin
      @(negedge clk);
      checkOutput("idle_ready", instr_ready, 1'b1);
      checkOutput("idle_busy", busy, 1'b0);
      checkOutput("idle_we3", we3, 1'b0);
      checkOutput("idle_z", z_flag, 1'b0);
    end

    // Single op: r2 = r5 + r1
    @(posedge clk); #1; instr = 16'h4A90; instr_valid = 1'b1;
    @(posedge clk); #1; instr_valid = 1'b0; instr = 16'hFFFF;
    @(negedge clk);
    checkOutput("c1_ra1", ra1, 3'd5);
    checkOutput("c1_ra2", ra2, 3'd1);
    checkOutput("c1_op", ula_control, 3'b010);
    checkOutput("c1_alu_src", alu_src, 1'b0);
    checkOutput("c1_we3", we3, 1'b0);
    @(negedge clk);
    checkOutput("c2_we3", we3, 1'b0);
    @(negedge clk);
    checkOutput("c3_we3", we3, 1'b1);
    checkOutput("c3_wa3", wa3, 3'd2);
    checkOutput("c3_done", done, 1'b1);
    @(negedge clk);
    checkOutput("c4_ready", instr_ready, 1'b1);
    checkOutput("c4_we3", we3, 1'b0);
    checkOutput("r2_result", rf[2], 8'h60);

    // Constant operand: r4 = r3 + 7
    applyStimulus(16'h5188, 1'b0);
    checkOutput("const_alu_src", alu_src, 1'b1);
    @(negedge clk);
    checkOutput("const_result", rf[4], 8'h37);

    // Zero flag captured in EXEC and held
    applyStimulus(16'h4A90, 1'b1);
    checkOutput("zero_wb", z_flag, 1'b1);
    repeat (3) begin
      @(negedge clk);
      checkOutput("zero_hold", z_flag, 1'b1);
    end

    // Write to r0 is suppressed
    p = we3_pulses;
    applyStimulus(16'h40A0, 1'b0);
    checkOutput("r0_done", done, 1'b1);
    checkOutput("r0_we3", we3, 1'b0);
    @(negedge clk);
    checkOutput("r0_pulses", 16'(we3_pulses - p), 16'd0);
    checkOutput("r0_value", rf[0], 8'h00);

    // Back-to-back with valid held high and instr changing every cycle
    @(posedge clk); #1; instr_valid = 1'b1;
    for (int c = 0; c < 17; c++) begin
      instr = 16'($urandom);
      z_in = 1'($urandom);
      @(negedge clk);
      if (instr_ready) accepts.push_back(c);
      @(posedge clk); #1;
    end
    z_in = 1'b0;
    checkOutput("b2b_accepts", 16'(accepts.size()), 16'd5);
    for (int i = 1; i < accepts.size(); i++)
      checkOutput("b2b_gap", 16'(accepts[i] - accepts[i-1]), 16'd4);

    // Reset asserted during EXEC
    n = 0;
    while (phase != 2 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    if (phase != 2) checkOutput("rst_wait_timeout", 1'b0, 1'b1);
    p = we3_pulses;
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; instr_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_ready", instr_ready, 1'b1);
    checkOutput("rst_z", z_flag, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("rst_no_write", 16'(we3_pulses - p), 16'd0);

    // Reset coinciding with a handshake drops the instruction
    @(posedge clk); #1; instr = 16'h4A90; instr_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; instr_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_hs_busy", busy, 1'b0);
`ifdef ULA_SEQ_PERF_EN
    checkOutput("perf_reset", instr_count, 16'd0);
`endif

    applyStimulus(16'h4A90, 1'b1);
    applyStimulus(16'h5188, 1'b1);
`ifdef ULA_SEQ_PERF_EN
    @(negedge clk);
    checkOutput("perf_count", instr_count, 16'd2);
    checkOutput("perf_zero", zero_count, 8'd2);
`endif
    repeat (4) @(negedge clk);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
